// File: rtl/counter_pkg.sv
// Shared definitions for the limit counter: counting mode encodings.
package counter_pkg;
  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } mode_e;
endpackage

// File: rtl/limit_next_calc.sv
// Combinational next-state for the limit counter: priority cfg_err > load > enable > hold,
// producing the next count and a boundary event on wrap/saturate/out-of-range recovery.
module limit_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min_limit,
  input  logic [WIDTH-1:0] max_limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             cfg_err,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary_evt
);

  function automatic logic [WIDTH-1:0] clamp_to_limits(input logic [WIDTH-1:0] v,
                                                       input logic [WIDTH-1:0] lo,
                                                       input logic [WIDTH-1:0] hi);
    logic [WIDTH-1:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

  logic               [WIDTH:0] sum;
  logic signed        [WIDTH:0] diff;
  logic signed        [WIDTH:0] min_s;
  logic                         sat;

  assign sum   = {1'b0, count} + {1'b0, step};
  assign diff  = $signed({1'b0, count}) - $signed({1'b0, step});
  assign min_s = $signed({1'b0, min_limit});
  assign sat   = (mode_e'(mode) == MODE_SATURATE);

  always_comb begin
    next_count   = count;
    boundary_evt = 1'b0;
    if (cfg_err) begin
      next_count = count;
    end else if (load) begin
      next_count = clamp_to_limits(load_value, min_limit, max_limit);
    end else if (enable) begin
      // Runtime limit changes can strand the count outside the window; recover first.
      if (count < min_limit) begin
        next_count   = min_limit;
        boundary_evt = 1'b1;
      end else if (count > max_limit) begin
        next_count   = max_limit;
        boundary_evt = 1'b1;
      end else if (up_down) begin
        if (sum > {1'b0, max_limit}) begin
          next_count   = sat ? max_limit : min_limit;
          boundary_evt = 1'b1;
        end else begin
          next_count = sum[WIDTH-1:0];
        end
      end else begin
        if (diff < min_s) begin
          next_count   = sat ? min_limit : max_limit;
          boundary_evt = 1'b1;
        end else begin
          next_count = diff[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/param_limit_counter.sv
// Up/down counter bounded by runtime limits with wrap or saturate behaviour.
// Holds only the count/boundary registers and the combinational status decode.
module param_limit_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min_limit,
  input  logic [WIDTH-1:0] max_limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             boundary,
  output logic             cfg_err
);

  logic [WIDTH-1:0] next_count;
  logic             boundary_evt;

  assign cfg_err = (min_limit > max_limit);
  assign at_max  = (count == max_limit);
  assign at_min  = (count == min_limit);

  limit_next_calc #(.WIDTH(WIDTH)) u_next (
    .count       (count),
    .enable      (enable),
    .up_down     (up_down),
    .mode        (mode),
    .step        (step),
    .min_limit   (min_limit),
    .max_limit   (max_limit),
    .load        (load),
    .load_value  (load_value),
    .cfg_err     (cfg_err),
    .next_count  (next_count),
    .boundary_evt(boundary_evt)
  );

  // Stage boundary: single register stage for count and the one-cycle boundary pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= INIT_VALUE;
      boundary <= 1'b0;
    end else begin
      count    <= next_count;
      boundary <= boundary_evt;
    end
  end

endmodule

// File: tb/tb_param_limit_counter.sv
// Scoreboard bench for param_limit_counter: directed scenarios plus randomized traffic
// against an integer reference model.
module tb_param_limit_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         enable = 1'b0, up_down = 1'b0, mode = 1'b0, load = 1'b0;
  logic [W-1:0] step = '0, min_limit = 8'd10, max_limit = 8'd20, load_value = '0;
  logic [W-1:0] count;
  logic         at_max, at_min, boundary, cfg_err;

  param_limit_counter #(.WIDTH(W), .INIT_VALUE(8'd7)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .mode(mode),
    .step(step), .min_limit(min_limit), .max_limit(max_limit), .load(load),
    .load_value(load_value), .count(count), .at_max(at_max), .at_min(at_min),
    .boundary(boundary), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit b;
    bit amax;
    bit amin;
    bit cerr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_count = 7;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Drives one cycle of inputs (caller is at a negedge) and queues the model's expectation.
  task automatic apply(input bit en, input bit ud, input bit md, input int st, input int mn,
                       input int mx, input bit ld, input int lv);
    exp_t e;
    int   nc;
    bit   nb;
    enable = en; up_down = ud; mode = md; step = W'(st);
    min_limit = W'(mn); max_limit = W'(mx); load = ld; load_value = W'(lv);
    nc = m_count;
    nb = 1'b0;
    if (mn > mx) begin
      nc = m_count;
    end else if (ld) begin
      nc = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
    end else if (en) begin
      if (m_count < mn) begin
        nc = mn; nb = 1'b1;
      end else if (m_count > mx) begin
        nc = mx; nb = 1'b1;
      end else if (ud) begin
        if (m_count + st > mx) begin nc = md ? mx : mn; nb = 1'b1; end
        else nc = m_count + st;
      end else begin
        if (m_count - st < mn) begin nc = md ? mn : mx; nb = 1'b1; end
        else nc = m_count - st;
      end
    end
    m_count = nc;
    e.c = nc; e.b = nb; e.amax = (nc == mx); e.amin = (nc == mn); e.cerr = (mn > mx);
    sb.push_back(e);
  endtask

  // Monitor: every update edge that has a queued expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_count", int'(count), e.c);
        chk("sb_boundary", int'(boundary), int'(e.b));
        chk("sb_at_max", int'(at_max), int'(e.amax));
        chk("sb_at_min", int'(at_min), int'(e.amin));
        chk("sb_cfg_err", int'(cfg_err), int'(e.cerr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int wrap_up[4] = '{13, 16, 19, 10};

  initial begin
    #2 reset_n = 1'b0;
    #2;
    chk("reset_count", int'(count), 7);
    chk("reset_boundary", int'(boundary), 0);
    repeat (2) @(posedge clk);
    #2 chk("reset_hold_count", int'(count), 7);
    @(negedge clk);
    reset_n = 1'b1;

    // Wrap up 10 -> 13,16,19,10
    @(negedge clk); apply(0, 1, 0, 3, 10, 20, 1, 10);
    @(posedge clk); #2 chk("wrap_load", int'(count), 10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); apply(1, 1, 0, 3, 10, 20, 0, 0);
      @(posedge clk); #2;
      chk("wrap_up_count", int'(count), wrap_up[i]);
      chk("wrap_up_boundary", int'(boundary), (i == 3) ? 1 : 0);
    end
    @(negedge clk); apply(0, 1, 0, 3, 10, 20, 0, 0);
    @(posedge clk); #2 chk("boundary_one_cycle", int'(boundary), 0);

    // Saturate up from 19
    @(negedge clk); apply(0, 1, 1, 3, 10, 20, 1, 19);
    @(posedge clk); #2 chk("sat_load", int'(count), 19);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); apply(1, 1, 1, 3, 10, 20, 0, 0);
      @(posedge clk); #2;
      chk("sat_count", int'(count), 20);
      chk("sat_boundary", int'(boundary), 1);
    end

    // Wrap down from 12 with step 4 -> 20, 16, 12
    @(negedge clk); apply(0, 0, 0, 4, 10, 20, 1, 12);
    @(posedge clk); #2;
    @(negedge clk); apply(1, 0, 0, 4, 10, 20, 0, 0);
    @(posedge clk); #2 chk("down_wrap_count", int'(count), 20);
    chk("down_wrap_boundary", int'(boundary), 1);
    @(negedge clk); apply(1, 0, 0, 4, 10, 20, 0, 0);
    @(posedge clk); #2 chk("down_count_16", int'(count), 16);
    chk("down_boundary_0", int'(boundary), 0);
    @(negedge clk); apply(1, 0, 0, 4, 10, 20, 0, 0);
    @(posedge clk); #2 chk("down_count_12", int'(count), 12);

    // Load clamp and load-over-enable priority
    @(negedge clk); apply(0, 1, 0, 3, 10, 20, 1, 250);
    @(posedge clk); #2 chk("load_clamp_count", int'(count), 20);
    chk("load_clamp_at_max", int'(at_max), 1);
    chk("load_clamp_boundary", int'(boundary), 0);
    @(negedge clk); apply(1, 1, 0, 3, 10, 20, 1, 15);
    @(posedge clk); #2 chk("load_wins", int'(count), 15);

    // Inverted limits freeze the count
    @(negedge clk); apply(1, 1, 0, 3, 30, 5, 0, 0);
    @(posedge clk); #2 chk("cfg_err_flag", int'(cfg_err), 1);
    chk("cfg_err_enable_hold", int'(count), 15);
    @(negedge clk); apply(0, 1, 0, 3, 30, 5, 1, 100);
    @(posedge clk); #2 chk("cfg_err_load_hold", int'(count), 15);

    // Mid-count reset discards a pending boundary pulse
    @(negedge clk); apply(0, 1, 1, 3, 10, 20, 1, 20);
    @(negedge clk); apply(1, 1, 1, 3, 10, 20, 0, 0);
    @(posedge clk); #2 chk("pre_reset_boundary", int'(boundary), 1);
    @(negedge clk);
    enable = 1'b0; load = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 7);
    chk("async_reset_boundary", int'(boundary), 0);
    @(posedge clk); #2 chk("in_reset_count", int'(count), 7);
    @(negedge clk);
    reset_n = 1'b1;
    m_count = 7;
    apply(1, 1, 0, 3, 0, 20, 0, 0);
    @(posedge clk); #2 chk("resume_count", int'(count), 10);

    // Randomized traffic, limits occasionally moved to strand the count
    begin
      int mn, mx, st, lv;
      bit en, ud, md, ld;
      mn = 10; mx = 200;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if ($urandom_range(0, 9) == 0) begin
          mn = $urandom_range(0, 120);
          mx = $urandom_range(100, 255);
          if ($urandom_range(0, 7) == 0) begin mn = $urandom_range(150, 255); mx = $urandom_range(0, 100); end
        end
        st = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 60);
        lv = $urandom_range(0, 255);
        en = ($urandom_range(0, 3) != 0);
        ud = $urandom_range(0, 1);
        md = $urandom_range(0, 1);
        ld = ($urandom_range(0, 9) == 0);
        apply(en, ud, md, st, mn, mx, ld, lv);
      end
    end
    @(negedge clk); enable = 1'b0; load = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_limit_counter.md
PARAM_LIMIT_COUNTER -- requirements
Module: param_limit_counter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, counter and limit width in bits (WIDTH >= 2).
- INIT_VALUE, 0, count value while reset is asserted.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, advance count this cycle.
- up_down, input, 1, 1 = up, 0 = down.
- mode, input, 1, 0 = WRAP, 1 = SATURATE.
- step, input, WIDTH, increment/decrement magnitude.
- min_limit, input, WIDTH, lower bound (inclusive).
- max_limit, input, WIDTH, upper bound (inclusive).
- load, input, 1, synchronous load request.
- load_value, input, WIDTH, value to load.
- count, output, WIDTH, registered counter value.
- at_max, output, 1, combinational: count == max_limit.
- at_min, output, 1, combinational: count == min_limit.
- boundary, output, 1, registered one-cycle pulse on a wrap or saturation event.
- cfg_err, output, 1, combinational: min_limit > max_limit.

Function
REQ-003 Priority SHALL be, per cycle: reset_n low > cfg_err > load > enable > hold.
REQ-004 While cfg_err = 1, count SHALL hold, and load and enable SHALL be ignored.
REQ-005 Load SHALL clamp load_value into [min_limit, max_limit] and write the result to count on the next edge; boundary SHALL be 0 for a load.
REQ-006 Counting up SHALL evaluate count + step in WIDTH+1 bits; if the sum is <= max_limit, count SHALL take the sum.
REQ-007 Up overrun (sum > max_limit) SHALL set count to min_limit in WRAP and to max_limit in SATURATE, and SHALL pulse boundary.
REQ-008 Counting down SHALL evaluate count - step in WIDTH+1 signed bits; if the result is >= min_limit, count SHALL take the result.
REQ-009 Down underrun (result < min_limit) SHALL set count to max_limit in WRAP and to min_limit in SATURATE, and SHALL pulse boundary.
REQ-010 In SATURATE, boundary SHALL also pulse when the count is already at the limit and is held there.
REQ-011 If count lies outside [min_limit, max_limit] (limits changed at runtime), an enabled cycle SHALL move count to the nearest limit and SHALL pulse boundary.
REQ-012 step = 0 with enable SHALL hold count and SHALL not pulse boundary, unless REQ-011 applies.
REQ-013 boundary SHALL be high for exactly the cycle after the triggering edge and SHALL return to 0 unless a new event occurs.
REQ-014 Latency from an enable or load sample to the count update SHALL be one clock.

Reset
REQ-015 While reset_n = 0, count SHALL equal INIT_VALUE and boundary SHALL equal 0, asynchronously.
REQ-016 After reset_n deasserts, counting SHALL resume on the first rising edge; a mid-count reset SHALL discard any pending boundary pulse.

Structure
REQ-017 A shared package counter_pkg SHALL hold the mode encodings (MODE_WRAP = 0, MODE_SATURATE = 1).
REQ-018 A combinational sub-module limit_next_calc SHALL compute the next count and the boundary event; the top SHALL hold only registers and output decode.

Verification
REQ-019 WIDTH=8, limits 10..20, step 3, WRAP, up from 10 -> 13, 16, 19, then 10 with boundary pulsed once.
REQ-020 Same setup in SATURATE, up from 19 -> 20 with boundary, then 20 with boundary on every further enabled cycle.
REQ-021 Limits 10..20, step 4, WRAP, down from 12 -> 20 with boundary; then 16, 12.
REQ-022 load_value 250 with limits 10..20 -> count 20, at_max = 1, boundary = 0; load together with enable -> load wins.
REQ-023 min_limit 30, max_limit 5 -> cfg_err = 1, count frozen under enable and load.
REQ-024 reset_n pulsed low mid-count with INIT_VALUE = 7 -> count = 7 immediately (no edge), boundary = 0, and counting resumes on the next edge.
